// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR fault monitor.
//   WIDTH / CNT_WIDTH / LOG_DEPTH : default replica width, counter width, event log depth
//   tmr_evt_t                     : logged event {mask, uncorr, tstamp}
//   maj3                          : single-bit two-of-three majority
package tmr_pkg;

  localparam int unsigned WIDTH     = 64;
  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned LOG_DEPTH = 4;

  typedef struct packed {
    logic [2:0]           mask;
    logic                 uncorr;
    logic [CNT_WIDTH-1:0] tstamp;
  } tmr_evt_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_evt_fifo.sv
// Synchronous event FIFO with a valid/ready drain port.
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : write request and payload (accepted unless full without pop)
//   drop_c            : combinational, push lost because FIFO is full and not popping
//   out_valid         : registered, head entry present
//   out_ready         : consumer accepts head
//   out_data          : head entry, read from registered storage
module tmr_evt_fifo
  import tmr_pkg::*;
#(
  parameter int unsigned depth = LOG_DEPTH,
  parameter type         evt_t = tmr_evt_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  evt_t push_data,
  output logic drop_c,
  output logic out_valid,
  input  logic out_ready,
  output evt_t out_data
);

  localparam int unsigned PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CNT_W = $clog2(depth + 1);

  evt_t             mem_q [depth];
  evt_t             mem_d [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             pop_c;
  logic             push_ok_c;
  logic             full_c;

  // Next-state: a pop frees a slot in the same cycle, so full+pop+push succeeds.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    full_c    = (count_q == CNT_W'(depth));
    pop_c     = valid_q && out_ready;
    push_ok_c = push && (!full_c || pop_c);
    drop_c    = push && full_c && !pop_c;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
    valid_d = (count_d != '0);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/tmr_fault_monitor.sv
// Receive-side TMR monitor: bitwise vote, per-replica fault flags, saturating
// fault counters, sampled timestamp and an event log drained over valid/ready.
//   clk, rst                : clock, synchronous active-high reset
//   sample, q_1..q_3        : capture strobe and replica values
//   clr                     : clear fault counters and overflow flag
//   voted_q, fault_vec,
//   uncorrectable           : registered vote results, updated on sample
//   fault_count_1..3        : saturating per-replica fault counts
//   evt_valid/ready, evt_*  : event log head and handshake
//   log_overflow            : sticky, an event was dropped on a full log
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int unsigned width     = WIDTH,
  parameter int unsigned cnt_width = CNT_WIDTH,
  parameter int unsigned log_depth = LOG_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample,
  input  logic [width-1:0]     q_1,
  input  logic [width-1:0]     q_2,
  input  logic [width-1:0]     q_3,
  input  logic                 clr,
  output logic [width-1:0]     voted_q,
  output logic [2:0]           fault_vec,
  output logic                 uncorrectable,
  output logic [cnt_width-1:0] fault_count_1,
  output logic [cnt_width-1:0] fault_count_2,
  output logic [cnt_width-1:0] fault_count_3,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [2:0]           evt_mask,
  output logic                 evt_uncorr,
  output logic [cnt_width-1:0] evt_time,
  output logic                 log_overflow
);

  typedef struct packed {
    logic [2:0]           mask;
    logic                 uncorr;
    logic [cnt_width-1:0] tstamp;
  } evt_t;

  logic [width-1:0]     maj_c;
  logic [2:0]           fault_c;
  logic                 uncorr_c;
  logic                 evt_push_c;
  evt_t                 evt_c;
  evt_t                 head;
  logic                 drop_c;

  logic [width-1:0]     vote_q, vote_d;
  logic [2:0]           fault_q, fault_d;
  logic                 uncorr_q, uncorr_d;
  logic [cnt_width-1:0] ts_q, ts_d;
  logic [cnt_width-1:0] cnt_q [3];
  logic [cnt_width-1:0] cnt_d [3];
  logic                 ovf_q, ovf_d;

  // Voting and event formation from the live replica inputs.
  always_comb begin
    maj_c = '0;
    for (int b = 0; b < int'(width); b++) maj_c[b] = maj3(q_1[b], q_2[b], q_3[b]);
    fault_c    = {(q_3 != maj_c), (q_2 != maj_c), (q_1 != maj_c)};
    uncorr_c   = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3);
    evt_push_c = sample && ((fault_c != 3'b000) || uncorr_c);
    evt_c        = '0;
    evt_c.mask   = fault_c;
    evt_c.uncorr = uncorr_c;
    evt_c.tstamp = ts_q;
  end

  // Next-state for vote registers, timestamp, counters and overflow; clr wins.
  always_comb begin
    vote_d   = vote_q;
    fault_d  = fault_q;
    uncorr_d = uncorr_q;
    ts_d     = ts_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (sample) begin
      vote_d   = maj_c;
      fault_d  = fault_c;
      uncorr_d = uncorr_c;
      ts_d     = ts_q + cnt_width'(1);
    end
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        cnt_d[i] = '0;
      end else if (sample && fault_c[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + cnt_width'(1);
      end
    end
    if (clr) begin
      ovf_d = 1'b0;
    end else if (drop_c) begin
      ovf_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vote_q   <= '0;
      fault_q  <= '0;
      uncorr_q <= 1'b0;
      ts_q     <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vote_q   <= vote_d;
      fault_q  <= fault_d;
      uncorr_q <= uncorr_d;
      ts_q     <= ts_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  tmr_evt_fifo #(
    .depth (log_depth),
    .evt_t (evt_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (evt_push_c),
    .push_data (evt_c),
    .drop_c    (drop_c),
    .out_valid (evt_valid),
    .out_ready (evt_ready),
    .out_data  (head)
  );

  assign voted_q       = vote_q;
  assign fault_vec     = fault_q;
  assign uncorrectable = uncorr_q;
  assign fault_count_1 = cnt_q[0];
  assign fault_count_2 = cnt_q[1];
  assign fault_count_3 = cnt_q[2];
  assign log_overflow  = ovf_q;
  assign evt_mask      = head.mask;
  assign evt_uncorr    = head.uncorr;
  assign evt_time      = head.tstamp;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed bench for tmr_fault_monitor with an event scoreboard and a behavioural model.
module tb_tmr_fault_monitor;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, sample, clr, evt_ready;
  logic [63:0] q_1, q_2, q_3;
  logic [63:0] voted_q;
  logic [2:0]  fault_vec;
  logic        uncorrectable;
  logic [15:0] fault_count_1, fault_count_2, fault_count_3;
  logic        evt_valid;
  logic [2:0]  evt_mask;
  logic        evt_uncorr;
  logic [15:0] evt_time;
  logic        log_overflow;

  tmr_fault_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .sample        (sample),
    .q_1           (q_1),
    .q_2           (q_2),
    .q_3           (q_3),
    .clr           (clr),
    .voted_q       (voted_q),
    .fault_vec     (fault_vec),
    .uncorrectable (uncorrectable),
    .fault_count_1 (fault_count_1),
    .fault_count_2 (fault_count_2),
    .fault_count_3 (fault_count_3),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_mask      (evt_mask),
    .evt_uncorr    (evt_uncorr),
    .evt_time      (evt_time),
    .log_overflow  (log_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mask;
    logic        u;
    logic [15:0] t;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  logic [63:0] vote_m;
  logic [2:0]  fault_m;
  logic        uncorr_m;
  logic [15:0] ts_m;
  logic [15:0] cnt_m [3];
  logic        ovf_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
  endtask

  task automatic reset_model();
    exp_q.delete();
    vote_m = '0; fault_m = '0; uncorr_m = 1'b0; ts_m = '0; ovf_m = 1'b0;
    for (int i = 0; i < 3; i++) cnt_m[i] = '0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".voted_q"}, voted_q, vote_m);
    chk({tag, ".fault_vec"}, 64'(fault_vec), 64'(fault_m));
    chk({tag, ".uncorrectable"}, 64'(uncorrectable), 64'(uncorr_m));
    chk({tag, ".fault_count_1"}, 64'(fault_count_1), 64'(cnt_m[0]));
    chk({tag, ".fault_count_2"}, 64'(fault_count_2), 64'(cnt_m[1]));
    chk({tag, ".fault_count_3"}, 64'(fault_count_3), 64'(cnt_m[2]));
    chk({tag, ".log_overflow"}, 64'(log_overflow), 64'(ovf_m));
    chk({tag, ".evt_valid"}, 64'(evt_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk({tag, ".head_mask"}, 64'(evt_mask), 64'(exp_q[0].mask));
      chk({tag, ".head_uncorr"}, 64'(evt_uncorr), 64'(exp_q[0].u));
      chk({tag, ".head_time"}, 64'(evt_time), 64'(exp_q[0].t));
    end
  endtask

  // One clock: drive inputs, compare any popped head, update the model, advance.
  task automatic cyc(input logic s, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] c, input logic rdy, input logic cl);
    logic [63:0] m;
    logic [2:0]  f;
    logic        u;
    logic        drop;
    exp_t        e;
    sample = s; q_1 = a; q_2 = b; q_3 = c; evt_ready = rdy; clr = cl;
    drop = 1'b0;
    f    = '0;
    if (rdy) chk("pop.evt_valid", 64'(evt_valid), 64'(exp_q.size() != 0));
    if (rdy && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pop.mask", 64'(evt_mask), 64'(e.mask));
      chk("pop.uncorr", 64'(evt_uncorr), 64'(e.u));
      chk("pop.time", 64'(evt_time), 64'(e.t));
    end
    if (s) begin
      for (int k = 0; k < 64; k++) m[k] = (int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2;
      f = {c != m, b != m, a != m};
      u = (a != b) && (a != c) && (b != c);
      vote_m = m; fault_m = f; uncorr_m = u;
      if (f != 3'b000 || u) begin
        if (exp_q.size() < DEPTH) begin
          e.mask = f; e.u = u; e.t = ts_m;
          exp_q.push_back(e);
        end else begin
          drop = 1'b1;
        end
      end
      ts_m = ts_m + 16'd1;
    end
    for (int i = 0; i < 3; i++) begin
      if (cl) cnt_m[i] = '0;
      else if (s && f[i] && cnt_m[i] != 16'hFFFF) cnt_m[i] = cnt_m[i] + 16'd1;
    end
    ovf_m = cl ? 1'b0 : (ovf_m | drop);
    @(posedge clk); #1;
    sample = 1'b0; clr = 1'b0; evt_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sample = 1'b0; clr = 1'b0; evt_ready = 1'b0;
    q_1 = '0; q_2 = '0; q_3 = '0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b0;

    // All replicas agree: no fault, no event.
    cyc(1'b1, 64'h5, 64'h5, 64'h5, 1'b0, 1'b0);
    check_state("agree");

    // Replica 1 disagrees; event carries timestamp 1.
    cyc(1'b1, 64'hF0, 64'h0F, 64'h0F, 1'b0, 1'b0);
    check_state("q1_fault");
    chk("q1_fault.time_const", 64'(evt_time), 64'd1);
    cyc(1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_state("q1_drain");

    // Three distinct replicas: uncorrectable.
    cyc(1'b1, 64'h1, 64'h2, 64'h4, 1'b0, 1'b0);
    check_state("uncorr");
    chk("uncorr.const", 64'(uncorrectable), 64'd1);
    cyc(1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);

    // Five faults without drain: four held, fifth dropped.
    repeat (5) cyc(1'b1, 64'h0, 64'h1, 64'h0, 1'b0, 1'b0);
    check_state("overflow");
    chk("overflow.const", 64'(log_overflow), 64'd1);
    cyc(1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    check_state("overflow_hold");
    repeat (4) cyc(1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_state("overflow_drained");
    cyc(1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
    check_state("clr");

    // Saturate replica 2's counter.
    repeat (65535) cyc(1'b1, 64'h0, 64'hA, 64'h0, 1'b0, 1'b0);
    check_state("sat_reach");
    cyc(1'b1, 64'h0, 64'hA, 64'h0, 1'b0, 1'b0);
    check_state("sat_hold");
    chk("sat_hold.const", 64'(fault_count_2), 64'hFFFF);
    repeat (4) cyc(1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_state("sat_drained");

    // clr with a fault in the same cycle: count cleared, event still logged.
    cyc(1'b1, 64'h0, 64'h0, 64'h8, 1'b0, 1'b1);
    check_state("clr_fault");
    cyc(1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);

    // Full FIFO with simultaneous pop and push: no overflow, stays at four.
    repeat (4) cyc(1'b1, 64'h3, 64'h0, 64'h0, 1'b0, 1'b0);
    check_state("full");
    cyc(1'b1, 64'h3, 64'h0, 64'h0, 1'b1, 1'b0);
    check_state("full_pop_push");
    repeat (4) cyc(1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_state("full_drained");

    // Reset mid-drain discards the log.
    repeat (3) cyc(1'b1, 64'h0, 64'h0, 64'h7, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_state("pre_reset");
    rst = 1'b1; evt_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; evt_ready = 1'b0;
    reset_model();
    check_state("mid_reset");
    cyc(1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_state("post_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
